// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types: register-file geometry and index helpers.
package cpu_pkg;
   localparam int NUM_REGS = 8;
   localparam int REG_AW   = 3;
   localparam int DATA_W   = 8;

   typedef logic [REG_AW-1:0] reg_idx_t;

   function automatic logic [NUM_REGS-1:0] idx_to_onehot(input reg_idx_t idx);
      logic [NUM_REGS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction
endpackage

// File: rtl/demux1_8.sv
// 1-to-8 demultiplexer: routes input bit i to output y[sel]; all other outputs low.
module demux1_8
   import cpu_pkg::*;
(
   input  logic                i,
   input  logic [REG_AW-1:0]   sel,
   output logic [NUM_REGS-1:0] y
);
   assign y = i ? idx_to_onehot(sel) : '0;
endmodule

// File: rtl/reg_file8.sv
// 8-entry register file: one decoded write port, two combinational read ports
// with optional write-through, and an unbypassed debug read port.
module reg_file8
   import cpu_pkg::*;
#(
   parameter int WIDTH     = DATA_W,
   parameter bit R0_ZERO   = 1'b1,
   parameter bit WR_BYPASS = 1'b1
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [REG_AW-1:0]   waddr,
   input  logic [WIDTH-1:0]    wdata,
   input  logic [REG_AW-1:0]   raddr_a,
   output logic [WIDTH-1:0]    rdata_a,
   input  logic [REG_AW-1:0]   raddr_b,
   output logic [WIDTH-1:0]    rdata_b,
   input  logic [REG_AW-1:0]   dbg_addr,
   output logic [WIDTH-1:0]    dbg_data,
   output logic [NUM_REGS-1:0] wr_onehot
);
   logic [NUM_REGS-1:0]            load_en;
   logic [NUM_REGS-1:0][WIDTH-1:0] regs;
   logic                           bypass_a;
   logic                           bypass_b;

   demux1_8 u_wr_dec (
      .i   (we),
      .sel (waddr),
      .y   (load_en)
   );

   assign wr_onehot = load_en;

   // Register 0 has no storage when hardwired, so every read of it is zero for free.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == 0 && R0_ZERO) begin : g_zero
            assign regs[gi] = '0;
         end else begin : g_store
            logic [WIDTH-1:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
               if (rst)
                  q_reg <= '0;
               else if (load_en[gi])
                  q_reg <= wdata;
            end
            assign regs[gi] = q_reg;
         end
      end
   endgenerate

   // Forward wdata only when the write will really land; never forward into hardwired r0.
   assign bypass_a = WR_BYPASS && we && !rst && (raddr_a == waddr)
                     && !(R0_ZERO && (raddr_a == '0));
   assign bypass_b = WR_BYPASS && we && !rst && (raddr_b == waddr)
                     && !(R0_ZERO && (raddr_b == '0));

   assign rdata_a  = bypass_a ? wdata : regs[raddr_a];
   assign rdata_b  = bypass_b ? wdata : regs[raddr_b];
   assign dbg_data = regs[dbg_addr];
endmodule

// File: doc/reg_file8.md
Name: reg_file8

Overview:
- 8-entry general-purpose register file for the single-cycle CPU datapath.
- Sits directly downstream of the 1-to-8 write-enable decoder (demux1_8). The decoder turns the 3-bit write address plus the write strobe into a one-hot enable vector; this block consumes that vector to load one register per clock.
- Provides two combinational read ports for the ALU operands and one debug read port.

Parameters:
- WIDTH, 8, data width of each register in bits.
- R0_ZERO, 1, when 1 register 0 always reads as zero and ignores writes.
- WR_BYPASS, 1, when 1 a read of the register being written in the same cycle returns wdata (write-through); when 0 it returns the stored value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write strobe, sampled at the rising edge of clk.
- waddr  input  3  write register index.
- wdata  input  WIDTH  write data.
- raddr_a  input  3  read port A index.
- rdata_a  output  WIDTH  read port A data, combinational.
- raddr_b  input  3  read port B index.
- rdata_b  output  WIDTH  read port B data, combinational.
- dbg_addr  input  3  debug read index.
- dbg_data  output  WIDTH  debug read data, combinational, never bypassed.
- wr_onehot  output  8  decoded write-enable vector, exposed for verification.

Behaviour:
- Reset:
  - rst high clears all 8 registers to 0 immediately, independent of clk.
  - While rst is high, writes are blocked, so rdata_a, rdata_b and dbg_data read 0 once the bypass gating below is applied.
  - Reset asserted in the same cycle as a write: reset wins and the register stays 0.
  - Deassertion of rst is synchronous to clk by the caller's contract. The first write takes effect at the first rising edge with rst low.
- Write decode:
  - wr_onehot = 1 << waddr when we=1, else 8'b0.
  - Exactly one bit is set per write and none when idle.
  - wr_onehot is combinational from we and waddr, with zero latency.
- Write:
  - At the rising edge, register k loads wdata if wr_onehot[k]=1.
  - Written data becomes visible on the non-bypassed path in the cycle after the edge.
- R0_ZERO=1:
  - wr_onehot[0] is still reported, but register 0 is not loaded.
  - Any read of index 0, on any port, returns 0. This includes bypass, so bypass never forwards to index 0.
- Read ports A and B:
  - Fully combinational: rdata = reg[raddr].
  - Bypass applies only when WR_BYPASS=1, we=1, rst=0, raddr==waddr, and not (R0_ZERO=1 and raddr=0). In that case rdata = wdata.
  - Both ports may address the same register; both return identical data.
  - Both ports may match waddr simultaneously; both are bypassed.
- Debug port:
  - dbg_data = reg[dbg_addr] with no bypass.
  - Reflects state only after the clock edge.
- Width: no arithmetic inside the block. Data passes unmodified; indices are 3 bits, so no out-of-range case exists.
- No X propagation: every output is defined for all input values after reset.

Decomposition:
- Shared package cpu_pkg:
  - NUM_REGS = 8, REG_AW = 3.
  - Typedef reg_idx_t (3 bits); default data width constant DATA_W = 8.
- Sub-module: instantiate the existing demux1_8 with i = we and sel = waddr. Its output drives wr_onehot and the per-register load enables.
- Storage: 8 WIDTH-bit registers, each with asynchronous clear on rst.

Test Plan:
- Reset: drive rst=1 mid-run after writing 8'hA5 to r3 -> dbg_data for r3 reads 0 immediately (before the next clk edge); rdata_a and rdata_b read 0.
- Basic write/read: we=1, waddr=5, wdata=8'h3C, one edge, then we=0 -> rdata_a with raddr_a=5 reads 8'h3C; wr_onehot was 8'b0010_0000 during the write and 8'b0 after.
- Bypass: reg r2=8'h11; same cycle we=1, waddr=2, wdata=8'h77, raddr_a=raddr_b=2 -> rdata_a=rdata_b=8'h77 before the edge while dbg_data=8'h11; after the edge dbg_data=8'h77. With WR_BYPASS=0, rdata_a=8'h11 before the edge.
- R0 hardwired: write 8'hFF to r0 -> wr_onehot=8'b0000_0001; rdata_a for raddr_a=0 reads 0 both in the write cycle and after.
- Sweep: write 8'h10+k to every rk for k=0..7, then read all via ports A, B and debug -> r0=0 (R0_ZERO=1), rk=8'h10+k for k≥1, no cross-talk.
- Reset during write: rst=1 coincident with we=1, waddr=6, wdata=8'h9A -> r6 stays 0 after rst is released.
